// File: rtl/mem_rd_arbiter_if.sv
// Bundle of the requester-side and memory-side read channels of mem_rd_arbiter.
// slave is the arbiter's view; master is the view of the requesters and memory around it.
interface mem_rd_arbiter_if #(
  parameter int REQUESTERS = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr;
  logic [REQUESTERS-1:0]            req_avalid;
  logic [REQUESTERS-1:0]            req_aready;
  logic [REQUESTERS-1:0]            rsp_dvalid;
  logic [DATA_WIDTH-1:0]            rsp_data;
  logic [ADDR_WIDTH-1:0]            m_r_addr;
  logic                             m_r_avalid;
  logic                             m_r_aready;
  logic                             m_r_dvalid;
  logic [DATA_WIDTH-1:0]            m_r_data;

  modport slave (
    input  req_addr, req_avalid, m_r_aready, m_r_dvalid, m_r_data,
    output req_aready, rsp_dvalid, rsp_data, m_r_addr, m_r_avalid
  );

  modport master (
    output req_addr, req_avalid, m_r_aready, m_r_dvalid, m_r_data,
    input  req_aready, rsp_dvalid, rsp_data, m_r_addr, m_r_avalid
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin read arbiter: shares one memory read port among REQUESTERS masters,
// tracks outstanding reads in issue order and routes each returned datum to its originator.
module mem_rd_arbiter #(
  parameter int REQUESTERS      = 3,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  mem_rd_arbiter_if.slave                   bus,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_unexpected
);
  localparam int ID_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(REQUESTERS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic [ID_W-1:0]       r_last_grant;
  logic [CNT_W-1:0]      r_outstanding;
  logic [ID_W-1:0]       r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic                  r_m_avalid;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [REQUESTERS-1:0] r_rsp_dvalid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_err;

  logic                  w_slot_free;
  logic                  w_fifo_empty;
  logic                  w_grant;
  logic                  w_pop;
  logic                  w_found;
  int                    w_idx_i;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W-1:0]       w_head;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [REQUESTERS-1:0] w_aready;
  logic [REQUESTERS-1:0] w_head_oh;

  // The ID FIFO holds exactly one entry per outstanding read, so the count doubles as its fill level.
  assign w_fifo_empty = (r_outstanding == '0);
  assign w_slot_free  = !r_m_avalid || bus.m_r_aready;
  assign w_pop        = bus.m_r_dvalid && !w_fifo_empty;
  assign w_head       = r_fifo[r_rd_ptr];

  always_comb begin
    w_found    = 1'b0;
    w_idx_i    = 0;
    w_idx      = '0;
    w_winner   = '0;
    w_win_addr = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      w_idx_i = (int'(r_last_grant) + k) % REQUESTERS;
      w_idx   = ID_W'(w_idx_i);
      if (!w_found && bus.req_avalid[w_idx]) begin
        w_found    = 1'b1;
        w_winner   = w_idx;
        w_win_addr = bus.req_addr[w_idx_i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign w_grant = w_slot_free && (r_outstanding < MAX_CNT) && w_found;

  always_comb begin
    w_aready = '0;
    if (w_grant) begin
      w_aready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_head_oh = '0;
    w_head_oh[w_head] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_avalid   <= 1'b0;
      r_m_addr     <= '0;
      r_last_grant <= LAST_ID;
    end else if (w_grant) begin
      r_m_avalid   <= 1'b1;
      r_m_addr     <= w_win_addr;
      r_last_grant <= w_winner;
    end else if (bus.m_r_aready) begin
      r_m_avalid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_grant, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_grant) begin
        r_fifo[r_wr_ptr] <= w_winner;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_dvalid <= '0;
      r_rsp_data   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_rsp_dvalid <= w_pop ? w_head_oh : '0;
      if (w_pop) begin
        r_rsp_data <= bus.m_r_data;
      end
      if (bus.m_r_dvalid && w_fifo_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.req_aready  = w_aready;
  assign bus.m_r_addr    = r_m_addr;
  assign bus.m_r_avalid  = r_m_avalid;
  assign bus.rsp_dvalid  = r_rsp_dvalid;
  assign bus.rsp_data    = r_rsp_data;
  assign outstanding     = r_outstanding;
  assign err_unexpected  = r_err;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: the bench plays both the requesters and the memory.
module tb_mem_rd_arbiter;
  localparam int REQ = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int MO  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] outstanding;
  logic       err_unexpected;
  int         n_vec  = 0;
  int         n_miss = 0;

  mem_rd_arbiter_if #(.REQUESTERS(REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_rd_arbiter #(
    .REQUESTERS(REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .outstanding(outstanding),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_avalid = '0;
    bus.m_r_dvalid = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req_addr   = '0;
    bus.req_avalid = '0;
    bus.m_r_aready = 1'b0;
    bus.m_r_dvalid = 1'b0;
    bus.m_r_data   = '0;
    repeat (3) cyc();
    check("rst_avalid", 32'(bus.m_r_avalid), 32'h0);
    check("rst_addr",   32'(bus.m_r_addr),   32'h0);
    check("rst_rspv",   32'(bus.rsp_dvalid), 32'h0);
    check("rst_rspd",   32'(bus.rsp_data),   32'h0);
    check("rst_outst",  32'(outstanding),    32'h0);
    check("rst_err",    32'(err_unexpected), 32'h0);
    reset_n = 1'b1;

    // single read from requester 1
    cyc();
    bus.req_addr[AW +: AW] = 16'h0010;
    bus.req_avalid = 3'b010;
    bus.m_r_aready = 1'b1;
    #1;
    check("t1_grant", 32'(bus.req_aready), 32'h2);
    cyc();
    bus.req_avalid = '0;
    #1;
    check("t1_avalid", 32'(bus.m_r_avalid), 32'h1);
    check("t1_addr",   32'(bus.m_r_addr),   32'h0010);
    check("t1_outst",  32'(outstanding),    32'h1);
    check("t1_nogrant", 32'(bus.req_aready), 32'h0);
    cyc();
    check("t1_avalid_off", 32'(bus.m_r_avalid), 32'h0);
    bus.m_r_dvalid = 1'b1;
    bus.m_r_data   = 16'hBEEF;
    cyc();
    bus.m_r_dvalid = 1'b0;
    check("t1_rspv",  32'(bus.rsp_dvalid), 32'h2);
    check("t1_rspd",  32'(bus.rsp_data),   32'hBEEF);
    check("t1_outst0", 32'(outstanding),   32'h0);
    cyc();
    check("t1_rspv_off", 32'(bus.rsp_dvalid), 32'h0);
    check("t1_rspd_hold", 32'(bus.rsp_data),  32'hBEEF);

    // round robin, all requesters asserting, data returned two cycles after grant
    do_reset();
    bus.req_addr = {16'h0102, 16'h0101, 16'h0100};
    bus.m_r_aready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.req_avalid = (k < 6) ? 3'b111 : 3'b000;
      bus.m_r_dvalid = (k >= 2 && k < 8);
      bus.m_r_data   = (k >= 2) ? 16'(16'hA000 + (k - 2) % 3) : 16'h0;
      #1;
      if (k < 6) check("rr_grant", 32'(bus.req_aready), oh(k % 3));
      else       check("rr_idle",  32'(bus.req_aready), 32'h0);
      if (k >= 1 && k <= 6) begin
        check("rr_avalid", 32'(bus.m_r_avalid), 32'h1);
        check("rr_addr",   32'(bus.m_r_addr),   32'(16'h0100 + (k - 1) % 3));
      end
      if (k == 2) check("rr_outst", 32'(outstanding), 32'h2);
      if (k == 7) check("rr_avalid_off", 32'(bus.m_r_avalid), 32'h0);
      if (k >= 3) begin
        check("rr_rspv", 32'(bus.rsp_dvalid), oh((k - 3) % 3));
        check("rr_rspd", 32'(bus.rsp_data),   32'(16'hA000 + (k - 3) % 3));
      end
      cyc();
    end
    bus.m_r_dvalid = 1'b0;
    check("rr_outst_end", 32'(outstanding), 32'h0);

    // backpressure on the memory address channel
    bus.m_r_aready = 1'b0;
    bus.req_addr[0 +: AW] = 16'h1234;
    bus.req_avalid = 3'b001;
    #1;
    check("bp_grant", 32'(bus.req_aready), 32'h1);
    cyc();
    bus.req_avalid = 3'b010;
    bus.req_addr[AW +: AW] = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_avalid", 32'(bus.m_r_avalid), 32'h1);
      check("bp_addr",   32'(bus.m_r_addr),   32'h1234);
      check("bp_nogrant", 32'(bus.req_aready), 32'h0);
      cyc();
    end
    bus.m_r_aready = 1'b1;
    #1;
    check("bp_addr_last", 32'(bus.m_r_addr), 32'h1234);
    check("bp_b2b_grant", 32'(bus.req_aready), 32'h2);
    cyc();
    bus.req_avalid = '0;
    #1;
    check("bp_addr2", 32'(bus.m_r_addr), 32'h5555);
    check("bp_avalid2", 32'(bus.m_r_avalid), 32'h1);
    check("bp_outst", 32'(outstanding), 32'h2);
    cyc();
    check("bp_avalid_off", 32'(bus.m_r_avalid), 32'h0);
    bus.m_r_dvalid = 1'b1;
    bus.m_r_data   = 16'h1111;
    cyc();
    bus.m_r_data   = 16'h2222;
    check("bp_rspv0", 32'(bus.rsp_dvalid), 32'h1);
    check("bp_rspd0", 32'(bus.rsp_data),   32'h1111);
    cyc();
    bus.m_r_dvalid = 1'b0;
    check("bp_rspv1", 32'(bus.rsp_dvalid), 32'h2);
    check("bp_rspd1", 32'(bus.rsp_data),   32'h2222);
    check("bp_outst0", 32'(outstanding),   32'h0);

    // outstanding limit: last grant was 1, so order is 2,0,1,2 then blocked
    for (int k = 0; k < 6; k++) begin
      bus.req_avalid = 3'b111;
      #1;
      check("lim_grant", 32'(bus.req_aready), (k < 4) ? oh((2 + k) % 3) : 32'h0);
      cyc();
    end
    check("lim_outst4", 32'(outstanding), 32'h4);
    bus.m_r_dvalid = 1'b1;
    bus.m_r_data   = 16'h4444;
    #1;
    check("lim_blocked", 32'(bus.req_aready), 32'h0);
    cyc();
    bus.m_r_dvalid = 1'b0;
    #1;
    check("lim_outst3", 32'(outstanding),    32'h3);
    check("lim_rspv",   32'(bus.rsp_dvalid), 32'h4);
    check("lim_rspd",   32'(bus.rsp_data),   32'h4444);
    check("lim_grant5", 32'(bus.req_aready), 32'h1);
    cyc();
    bus.req_avalid = '0;
    check("lim_outst4b", 32'(outstanding), 32'h4);
    check("lim_addr5",   32'(bus.m_r_addr), 32'h1234);
    for (int j = 0; j < 4; j++) begin
      bus.m_r_dvalid = 1'b1;
      bus.m_r_data   = 16'(16'h4500 + j);
      cyc();
      check("lim_drain_v", 32'(bus.rsp_dvalid), oh(j % 3));
      check("lim_drain_d", 32'(bus.rsp_data),   32'(16'h4500 + j));
    end
    bus.m_r_dvalid = 1'b0;
    check("lim_outst0", 32'(outstanding), 32'h0);

    // spurious data with nothing outstanding
    bus.m_r_dvalid = 1'b1;
    bus.m_r_data   = 16'hDEAD;
    cyc();
    bus.m_r_dvalid = 1'b0;
    check("sp_err",   32'(err_unexpected), 32'h1);
    check("sp_rspv",  32'(bus.rsp_dvalid), 32'h0);
    check("sp_rspd",  32'(bus.rsp_data),   32'h4503);
    check("sp_outst", 32'(outstanding),    32'h0);
    cyc();
    check("sp_err_sticky", 32'(err_unexpected), 32'h1);

    // reset with three reads in flight
    bus.req_avalid = 3'b111;
    repeat (3) cyc();
    check("mr_outst3", 32'(outstanding),    32'h3);
    check("mr_avalid", 32'(bus.m_r_avalid), 32'h1);
    reset_n = 1'b0;
    bus.req_avalid = '0;
    #1;
    check("mr_rst_avalid", 32'(bus.m_r_avalid), 32'h0);
    check("mr_rst_addr",   32'(bus.m_r_addr),   32'h0);
    check("mr_rst_outst",  32'(outstanding),    32'h0);
    check("mr_rst_err",    32'(err_unexpected), 32'h0);
    check("mr_rst_rspd",   32'(bus.rsp_data),   32'h0);
    cyc();
    reset_n = 1'b1;
    bus.req_avalid = 3'b111;
    bus.m_r_dvalid = 1'b1;
    bus.m_r_data   = 16'h7777;
    #1;
    check("mr_first_grant", 32'(bus.req_aready), 32'h1);
    cyc();
    bus.req_avalid = '0;
    bus.m_r_dvalid = 1'b0;
    check("mr_late_err",  32'(err_unexpected), 32'h1);
    check("mr_outst1",    32'(outstanding),    32'h1);
    check("mr_rspv",      32'(bus.rsp_dvalid), 32'h0);
    check("mr_addr",      32'(bus.m_r_addr),   32'h1234);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares one read port of the memory UUT (r_addr/r_avalid/r_aready in, r_dvalid/r_data back) between REQUESTERS read masters.
- Fair round-robin arbitration on the address channel, registered address output, in-order tracking of outstanding reads (requester-ID FIFO), routing of each returned datum to its originator.
- Sits between the per-requester read drivers and the UUT read channel.

Parameters:
- REQUESTERS, 3, number of read masters.
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 16, data width.
- MAX_OUTSTANDING, 4, max reads accepted but not yet returned; ID FIFO depth; power of 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_addr  in  REQUESTERS*ADDR_WIDTH  per-requester address, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_avalid  in  REQUESTERS  per-requester read request.
- req_aready  out  REQUESTERS  one-hot accept, combinational.
- rsp_dvalid  out  REQUESTERS  one-hot response strobe, registered.
- rsp_data  out  DATA_WIDTH  response data, registered, shared by all requesters.
- m_r_addr  out  ADDR_WIDTH  address to UUT, registered.
- m_r_avalid  out  1  address valid to UUT, registered.
- m_r_aready  in  1  UUT address accept.
- m_r_dvalid  in  1  UUT read data valid, one cycle per read, in issue order.
- m_r_data  in  DATA_WIDTH  UUT read data.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current count of accepted, unreturned reads.
- err_unexpected  out  1  sticky: m_r_dvalid seen with no outstanding read.

Behaviour:
- Reset (async assert, sync release): m_r_avalid=0, m_r_addr=0, rsp_dvalid=0, rsp_data=0, outstanding=0, err_unexpected=0, ID FIFO empty, rr pointer last_grant=REQUESTERS-1 (requester 0 has first priority).
- Slot free: slot_free = !m_r_avalid || m_r_aready.
- Grant condition: slot_free && outstanding < MAX_OUTSTANDING && |req_avalid.
- Winner: first asserted req_avalid searching last_grant+1, last_grant+2, ... modulo REQUESTERS.
- Grant cycle:
  - req_aready[winner]=1, all others 0.
  - Next edge: m_r_addr <= req_addr[winner], m_r_avalid <= 1, winner ID pushed to FIFO, last_grant <= winner.
  - No grant: req_aready=0.
- Requester rule: req_avalid and req_addr held stable until req_aready.
- Address hold: m_r_avalid with m_r_addr stays asserted and stable until m_r_aready. If m_r_aready=1 and no new grant, m_r_avalid <= 0. Back-to-back issue (one read per cycle) is supported.
- Counting:
  - outstanding increments on grant, decrements on m_r_dvalid with FIFO non-empty.
  - Both in the same cycle: count unchanged.
  - At MAX_OUTSTANDING: no grant. A slot freed by this cycle's m_r_dvalid is usable the next cycle.
- Response path: on m_r_dvalid with FIFO non-empty, pop head ID h. Next cycle rsp_dvalid[h]=1 and rsp_data=m_r_data (latency 1). Otherwise rsp_dvalid=0 and rsp_data holds its last value.
- Empty-FIFO response: m_r_dvalid with FIFO empty sets err_unexpected=1 (cleared only by reset); no rsp_dvalid, count unchanged.
- FIFO: pointers wrap modulo MAX_OUTSTANDING; push and pop in the same cycle are both honoured, including at full (pop frees, but the grant is already blocked by the count) and at empty+push (no pop).
- Reset mid-operation: all in-flight tracking discarded. Data the UUT returns after reset flags err_unexpected. The bench resets the UUT together with this block.

Test Plan:
- Single read: req 1 addr 0x0010 alone, UUT aready=1, data 0xBEEF 2 cycles later -> req_aready=2'b010 cycle 0; m_r_addr=0x0010 valid cycle 1; rsp_dvalid=3'b010, rsp_data=0xBEEF one cycle after m_r_dvalid.
- Round robin: all 3 requesters assert continuously, aready=1 -> grant order 0,1,2,0,1,2, one per cycle; each datum (0xA000+id) returned to the matching rsp_dvalid bit, in order.
- Backpressure: m_r_aready=0 for 5 cycles with req 0 at 0x1234 -> m_r_avalid=1, m_r_addr=0x1234 stable all 5 cycles; no further grant; issue completes on the aready cycle.
- Outstanding limit: 6 requests, aready=1, no dvalid -> exactly 4 granted, outstanding=4, req_aready=0. One dvalid -> outstanding 3, 5th grant the cycle after.
- Spurious data: m_r_dvalid with nothing outstanding -> err_unexpected=1 and stays set, rsp_dvalid=0, outstanding=0.
- Reset mid-stream: reset_n low with 3 outstanding and m_r_avalid=1 -> all outputs return to reset values immediately; after release req 0 is granted first.
